sha1ctrl: RTL and testbench

Round sequencer for the SHA-1 compression core. For each 512-bit block it generates the round index t (0..79) and the `en` for the `sha1shift` message-schedule register, which selects the external word for t<16 and feedback otherwise. It also drives the round-function select, the round constant K, and the hash-state strobes (init, round, add-back). It sits between the block source and the `sha1shift` / A..E / H0..H4 datapath and runs one block per start handshake, without stalls.

---
 rtl/sha1ctrl.sv | 58 +++++
 tb/tb_sha1ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/sha1ctrl.sv
// sha1ctrl: round sequencer driving the SHA-1 message schedule, round logic and hash-state strobes
module sha1ctrl #(
    parameter int NBLK_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              first,
    output logic              ready,
    output logic              busy,
    output logic              sched_en,
    output logic              word_req,
    output logic [3:0]        word_idx,
    output logic [6:0]        t,
    output logic [1:0]        fsel,
    output logic [31:0]       k,
    output logic              init_h,
    output logic              load_abcde,
    output logic              round_en,
    output logic              add_en,
    output logic              done,
    output logic [NBLK_W-1:0] nblk
);
    typedef enum logic [1:0] {IDLE, ROUND, ADD} state_t;
    state_t state, state_n;

    // Decode strobes, round parameters and next state from the current state and t
    always_comb begin
        ready      = state == IDLE;
        busy       = !ready;
        init_h     = ready && start && first;
        load_abcde = ready && start && !first;
        round_en   = state == ROUND;
        add_en     = state == ADD;
        sched_en   = round_en && t < 7'd16;
        word_req   = sched_en;
        word_idx   = sched_en ? t[3:0] : 4'd0;
        fsel       = !round_en ? 2'd0 : t < 7'd20 ? 2'd0 : t < 7'd40 ? 2'd1 : t < 7'd60 ? 2'd2 : 2'd3;
        k          = !round_en ? 32'h0 : t < 7'd20 ? 32'h5A827999 : t < 7'd40 ? 32'h6ED9EBA1 :
                     t < 7'd60 ? 32'h8F1BBCDC : 32'hCA62C1D6;
        state_n    = ready ? (start ? ROUND : IDLE) : round_en ? (t == 7'd79 ? ADD : ROUND) : IDLE;
    end

    // State, round counter, done pulse and completed-block count; t rests at 0 outside ROUND
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            t     <= '0;
            done  <= 1'b0;
            nblk  <= '0;
        end else begin
            state <= state_n;
            t     <= (round_en && t != 7'd79) ? t + 7'd1 : 7'd0;
            done  <= add_en;
            nblk  <= nblk + NBLK_W'(add_en);
        end
    end
endmodule

// File: tb/tb_sha1ctrl.sv
// tb_sha1ctrl: directed bench for sha1ctrl with a behavioural SHA-1 schedule/datapath attached
module tb_sha1ctrl;
    logic clk = 0, reset = 1, start = 0, first = 0;
    logic ready, busy, sched_en, word_req, init_h, load_abcde, round_en, add_en, done;
    logic [3:0] word_idx;
    logic [6:0] t;
    logic [1:0] fsel;
    logic [31:0] k;
    logic [15:0] nblk;
    int checks = 0, errors = 0;

    sha1ctrl #(.NBLK_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .first(first), .ready(ready), .busy(busy),
        .sched_en(sched_en), .word_req(word_req), .word_idx(word_idx), .t(t), .fsel(fsel), .k(k),
        .init_h(init_h), .load_abcde(load_abcde), .round_en(round_en), .add_en(add_en),
        .done(done), .nblk(nblk)
    );

    always #5 clk = ~clk;

    // Message "abc" padded into one block
    logic [31:0] msg [16];
    initial begin
        for (int i = 0; i < 16; i++) msg[i] = 32'h0;
        msg[0]  = 32'h61626380;
        msg[15] = 32'h00000018;
    end

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] rf(input logic [1:0] s, input logic [31:0] x, y, z);
        if (s == 2'd0) return (x & y) | (~x & z);
        if (s == 2'd2) return (x & y) | (x & z) | (y & z);
        return x ^ y ^ z;
    endfunction

    logic [31:0] ws [16];
    logic [31:0] h [5];
    logic [31:0] a, b, c, d, e, win, wt;
    assign win = word_req ? msg[word_idx] : 32'h0;
    assign wt  = sched_en ? win : rotl(ws[13] ^ ws[8] ^ ws[2] ^ ws[0], 1);

    // Schedule shifter plus A..E / H0..H4 datapath, steered only by the controller strobes
    always @(posedge clk) begin
        for (int i = 0; i < 15; i++) ws[i] <= ws[i + 1];
        ws[15] <= wt;
        if (init_h) begin
            h[0] <= 32'h67452301; h[1] <= 32'hEFCDAB89; h[2] <= 32'h98BADCFE;
            h[3] <= 32'h10325476; h[4] <= 32'hC3D2E1F0;
            a <= 32'h67452301; b <= 32'hEFCDAB89; c <= 32'h98BADCFE;
            d <= 32'h10325476; e <= 32'hC3D2E1F0;
        end else if (load_abcde) begin
            a <= h[0]; b <= h[1]; c <= h[2]; d <= h[3]; e <= h[4];
        end else if (round_en) begin
            a <= rotl(a, 5) + rf(fsel, b, c, d) + e + k + wt;
            b <= a; c <= rotl(b, 30); d <= c; e <= d;
        end else if (add_en) begin
            h[0] <= h[0] + a; h[1] <= h[1] + b; h[2] <= h[2] + c;
            h[3] <= h[3] + d; h[4] <= h[4] + e;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs cycles 1..82 of a block whose start was accepted at the current cycle
    task automatic run_block(input logic [15:0] nexp, input bit chain);
        int nround = 0, nsched = 0;
        logic [31:0] kexp;
        logic [1:0] fexp;
        for (int i = 1; i <= 82; i++) begin
            @(negedge clk);
            start = (i == 30 || i == 81 || (i == 82 && chain));
            first = (i != 82);
            #1;
            nround += round_en;
            nsched += sched_en;
            chk("busy_vs_ready", busy, !ready);
            chk("ready", ready, i == 82);
            chk("sched_en", sched_en, i <= 16);
            chk("word_req", word_req, i <= 16);
            chk("word_idx", word_idx, i <= 16 ? i - 1 : 0);
            chk("round_en", round_en, i <= 80);
            chk("t", t, i <= 80 ? i - 1 : 0);
            chk("add_en", add_en, i == 81);
            chk("done", done, i == 82);
            chk("init_h", init_h, 0);
            chk("load_abcde", load_abcde, i == 82 && chain);
            if (i <= 20)      begin fexp = 0; kexp = 32'h5A827999; end
            else if (i <= 40) begin fexp = 1; kexp = 32'h6ED9EBA1; end
            else if (i <= 60) begin fexp = 2; kexp = 32'h8F1BBCDC; end
            else if (i <= 80) begin fexp = 3; kexp = 32'hCA62C1D6; end
            else              begin fexp = 0; kexp = 32'h0; end
            chk("fsel", fsel, fexp);
            chk("k", k, kexp);
            if (i == 20) chk("k_t19", k, 32'h5A827999);
            if (i == 21) chk("fsel_t20", fsel, 1);
            if (i == 21) chk("k_t20", k, 32'h6ED9EBA1);
            if (i == 80) chk("k_t79", k, 32'hCA62C1D6);
            if (i == 80) chk("fsel_t79", fsel, 3);
        end
        chk("round_count", nround, 80);
        chk("sched_count", nsched, 16);
        chk("nblk", nblk, nexp);
    endtask

    initial begin
        bit seen;
        repeat (2) @(negedge clk);
        reset = 0;
        repeat (10) begin
            @(negedge clk);
            #1;
            chk("idle_ready", ready, 1);
            chk("idle_busy", busy, 0);
            chk("idle_strobes", {sched_en, word_req, round_en, add_en, done, init_h, load_abcde}, 0);
            chk("idle_t", t, 0);
            chk("idle_nblk", nblk, 0);
            chk("idle_word_idx", word_idx, 0);
            chk("idle_fsel", fsel, 0);
            chk("idle_k", k, 0);
        end
        @(negedge clk);
        start = 1; first = 1;
        #1;
        chk("start_init_h", init_h, 1);
        chk("start_load_abcde", load_abcde, 0);
        run_block(16'd1, 1'b1);
        chk("H0", h[0], 32'ha9993e36);
        chk("H1", h[1], 32'h4706816a);
        chk("H2", h[2], 32'hba3e2571);
        chk("H3", h[3], 32'h7850c26c);
        chk("H4", h[4], 32'h9cd0d89d);
        chk("chain_init_h", init_h, 0);
        chk("chain_load_abcde", load_abcde, 1);
        run_block(16'd2, 1'b0);
        @(negedge clk);
        start = 1; first = 1;
        #1;
        chk("third_init_h", init_h, 1);
        for (int i = 1; i <= 41; i++) begin
            @(negedge clk);
            start = 0;
        end
        #1;
        chk("pre_reset_t", t, 40);
        reset = 1; start = 1;
        @(negedge clk);
        reset = 0; start = 0;
        #1;
        chk("rst_ready", ready, 1);
        chk("rst_t", t, 0);
        chk("rst_nblk", nblk, 0);
        chk("rst_round_en", round_en, 0);
        seen = 0;
        repeat (100) begin
            @(negedge clk);
            #1;
            seen |= done | add_en | round_en;
        end
        chk("rst_no_done_add", seen, 0);
        chk("rst_final_nblk", nblk, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
